// File: rtl/ring_phase_gen_mc.sv
// Multi-channel circular phase generator feeding the CORDIC angle input.
// Per-channel programmable range/step, round-robin onto one valid/ready stream.
module ring_phase_gen_mc #(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     NUM_CH    = 2,
    parameter int unsigned     CH_W      = 1,
    parameter logic [WIDTH-1:0] START_DEF = 16'd8191,
    parameter logic [WIDTH-1:0] END_DEF   = 16'd57344,
    parameter bit              DIR_DEF   = 1'b0
) (
    input  logic             CLK,
    input  logic             SCLR_N,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_end,
    input  logic             cfg_dir,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic             en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CH_W-1:0]  m_ch,
    output logic             m_wrap
);

    localparam int unsigned      CNT_W    = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] DIFF_DEF = DIR_DEF ? (END_DEF - START_DEF) : (START_DEF - END_DEF);
    localparam logic [WIDTH:0]   LEN_DEF  = {1'b0, DIFF_DEF} + (WIDTH+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DIV, S_COMMIT} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_cfg_ready;
    logic [CH_W-1:0]  r_cfg_ch;
    logic [WIDTH-1:0] r_cfg_start, r_cfg_end, r_cfg_step;
    logic             r_cfg_dir;
    logic [WIDTH:0]   r_len;
    logic [WIDTH-1:0] r_rem, r_dvd;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_ch_start [NUM_CH];
    logic             r_ch_dir   [NUM_CH];
    logic [WIDTH:0]   r_ch_len   [NUM_CH];
    logic [WIDTH-1:0] r_ch_step  [NUM_CH];
    logic [WIDTH-1:0] r_ch_off   [NUM_CH];
    logic             r_ch_wrap  [NUM_CH];

    logic [CH_W-1:0]  r_rr;
    logic             r_m_valid, r_m_wrap;
    logic [WIDTH-1:0] r_m_data;
    logic [CH_W-1:0]  r_m_ch;

    logic             w_cfg_acc, w_fire;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH:0]   w_rem_sh, w_rem_nxt;
    logic [WIDTH-1:0] w_start, w_off, w_step, w_val, w_off_nxt;
    logic             w_dir, w_wrap, w_wrap_nxt;
    logic [WIDTH:0]   w_len, w_sum;

    assign w_cfg_acc = cfg_valid && (r_state == S_IDLE);
    assign w_fire    = en && (r_state == S_IDLE) && (!r_m_valid || m_ready);

    // Config sequencer: accept, compute length, divide, commit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_cfg_acc) w_state_nxt = S_LEN;
            S_LEN:    w_state_nxt = S_DIV;
            S_DIV:    if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge SCLR_N) begin
        if (!SCLR_N) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cfg_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // Restoring division step: remainder of latched step over range length.
    assign w_diff    = r_cfg_dir ? (r_cfg_end - r_cfg_start) : (r_cfg_start - r_cfg_end);
    assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
    assign w_rem_nxt = (w_rem_sh >= r_len) ? (w_rem_sh - r_len) : w_rem_sh;

    always_ff @(posedge CLK or negedge SCLR_N) begin
        if (!SCLR_N) begin
            r_cfg_ch    <= '0;
            r_cfg_start <= '0;
            r_cfg_end   <= '0;
            r_cfg_dir   <= 1'b0;
            r_cfg_step  <= '0;
            r_len       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_cfg_acc) begin
                r_cfg_ch    <= cfg_ch;
                r_cfg_start <= cfg_start;
                r_cfg_end   <= cfg_end;
                r_cfg_dir   <= cfg_dir;
                r_cfg_step  <= cfg_step;
            end
            if (r_state == S_LEN) begin
                r_len <= {1'b0, w_diff} + (WIDTH+1)'(1);
                r_rem <= '0;
                r_dvd <= r_cfg_step;
                r_cnt <= '0;
            end else if (r_state == S_DIV) begin
                r_rem <= WIDTH'(w_rem_nxt);
                r_dvd <= r_dvd << 1;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Round-robin channel select and next-offset arithmetic.
    always_comb begin
        w_start = r_ch_start[0];
        w_dir   = r_ch_dir[0];
        w_len   = r_ch_len[0];
        w_step  = r_ch_step[0];
        w_off   = r_ch_off[0];
        w_wrap  = r_ch_wrap[0];
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (r_rr == CH_W'(i)) begin
                w_start = r_ch_start[i];
                w_dir   = r_ch_dir[i];
                w_len   = r_ch_len[i];
                w_step  = r_ch_step[i];
                w_off   = r_ch_off[i];
                w_wrap  = r_ch_wrap[i];
            end
        end
        w_sum      = {1'b0, w_off} + {1'b0, w_step};
        w_wrap_nxt = (w_sum >= w_len);
        w_off_nxt  = WIDTH'(w_wrap_nxt ? (w_sum - w_len) : w_sum);
        w_val      = w_dir ? (w_start + w_off) : (w_start - w_off);
    end

    always_ff @(posedge CLK or negedge SCLR_N) begin
        if (!SCLR_N) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_ch_start[i] <= START_DEF;
                r_ch_dir[i]   <= DIR_DEF;
                r_ch_len[i]   <= LEN_DEF;
                r_ch_step[i]  <= '0;
                r_ch_off[i]   <= '0;
                r_ch_wrap[i]  <= 1'b0;
            end
            r_rr      <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_ch    <= '0;
            r_m_wrap  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if ((r_state == S_COMMIT) && (r_cfg_ch == CH_W'(i))) begin
                    r_ch_start[i] <= r_cfg_start;
                    r_ch_dir[i]   <= r_cfg_dir;
                    r_ch_len[i]   <= r_len;
                    r_ch_step[i]  <= r_rem;
                    r_ch_off[i]   <= '0;
                    r_ch_wrap[i]  <= 1'b0;
                end else if (w_fire && (r_rr == CH_W'(i))) begin
                    r_ch_off[i]  <= w_off_nxt;
                    r_ch_wrap[i] <= w_wrap_nxt;
                end
            end
            if (w_fire) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_val;
                r_m_ch    <= r_rr;
                r_m_wrap  <= w_wrap;
                r_rr      <= (r_rr == CH_W'(NUM_CH-1)) ? '0 : (r_rr + CH_W'(1));
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_ch      = r_m_ch;
    assign m_wrap    = r_m_wrap;

endmodule

// File: tb/tb_ring_phase_gen_mc.sv
// Directed bench for ring_phase_gen_mc: expected beats queued up front,
// popped and compared as the sink accepts each beat.
module tb_ring_phase_gen_mc;

    logic        CLK, SCLR_N;
    logic        cfg_valid, cfg_ready, cfg_dir;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_start, cfg_end, cfg_step;
    logic        en, m_valid, m_ready, m_wrap;
    logic [15:0] m_data;
    logic [0:0]  m_ch;

    typedef struct {
        logic [15:0] data;
        logic        ch;
        logic        wrap;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;
    bit    tb_rr = 1'b0;

    ring_phase_gen_mc dut (
        .CLK(CLK), .SCLR_N(SCLR_N),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_dir(cfg_dir), .cfg_step(cfg_step),
        .en(en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_ch(m_ch), .m_wrap(m_wrap)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Queue one ch0 beat; ch1 is never reconfigured so it always yields 8191.
    task automatic exp0(input logic [15:0] d, input logic w);
        if (tb_rr) sb.push_back('{data: 16'd8191, ch: 1'b1, wrap: 1'b0});
        sb.push_back('{data: d, ch: 1'b0, wrap: w});
        tb_rr = 1'b1;
    endtask

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge CLK);
            if (SCLR_N && m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 32'(m_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 32'(m_data), 32'(e.data));
                    chk("beat_ch", 32'(m_ch), 32'(e.ch));
                    chk("beat_wrap", 32'(m_wrap), 32'(e.wrap));
                end
            end
        end
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #2;
            if (sb.size() == 0) break;
        end
        chk("sb_drained", 32'(sb.size()), 0);
    endtask

    task automatic run(input int n);
        @(posedge CLK); #1 en = 1'b1;
        repeat (n) @(posedge CLK);
        #1 en = 1'b0;
        wait_empty();
    endtask

    // Three beats, then sink stalls 5 cycles with en still high, then the rest.
    task automatic run_bp(input int n);
        beat_t f;
        @(posedge CLK); #1 en = 1'b1;
        repeat (3) @(posedge CLK);
        #1 m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            f = (sb.size() != 0) ? sb[0] : '{data: 16'hxxxx, ch: 1'bx, wrap: 1'bx};
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_data", 32'(m_data), 32'(f.data));
            chk("hold_ch", 32'(m_ch), 32'(f.ch));
            chk("hold_wrap", 32'(m_wrap), 32'(f.wrap));
        end
        @(posedge CLK); #1 m_ready = 1'b1;
        repeat (n - 3) @(posedge CLK);
        #1 en = 1'b0;
        wait_empty();
    endtask

    // Configure with the output idle; en is raised during the busy window to
    // prove no beat is generated while the channel is being reprogrammed.
    task automatic configure(input logic ch, input logic [15:0] st, input logic [15:0] ed,
                             input logic dir, input logic [15:0] step);
        @(posedge CLK); #1 en = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        cfg_ch = ch; cfg_start = st; cfg_end = ed; cfg_dir = dir; cfg_step = step;
        cfg_valid = 1'b1;
        @(posedge CLK); #1 cfg_valid = 1'b0; en = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge CLK);
            chk("busy_cfg_ready", 32'(cfg_ready), 0);
            chk("busy_m_valid", 32'(m_valid), 0);
            if (k == 17) en = 1'b0;
        end
        @(negedge CLK);
        chk("cfg_ready_back", 32'(cfg_ready), 1);
    endtask

    initial begin
        SCLR_N = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_start = '0; cfg_end = '0;
        cfg_dir = 1'b0; cfg_step = '0; en = 1'b0; m_ready = 1'b1;
        fork monitor(); join_none
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_ch", 32'(m_ch), 0);
        chk("rst_m_wrap", 32'(m_wrap), 0);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        @(posedge CLK); #1 SCLR_N = 1'b1;

        // Default down range 8191..57344, step 4096 (L=16384).
        configure(1'b0, 16'd8191, 16'd57344, 1'b0, 16'd4096);
        exp0(16'd8191, 1'b0); exp0(16'd4095, 1'b0); exp0(16'd65535, 1'b0);
        exp0(16'd61439, 1'b0); exp0(16'd8191, 1'b1);
        run(sb.size());

        // Up range 100..109, step 23 reduces to 3.
        configure(1'b0, 16'd100, 16'd109, 1'b1, 16'd23);
        exp0(16'd100, 1'b0); exp0(16'd103, 1'b0); exp0(16'd106, 1'b0); exp0(16'd109, 1'b0);
        exp0(16'd102, 1'b1); exp0(16'd105, 1'b0); exp0(16'd108, 1'b0); exp0(16'd101, 1'b1);
        run(sb.size());

        // Range crossing zero, L=12, with a sink stall mid-sequence.
        configure(1'b0, 16'd65530, 16'd5, 1'b1, 16'd4);
        exp0(16'd65530, 1'b0); exp0(16'd65534, 1'b0); exp0(16'd2, 1'b0);
        exp0(16'd65530, 1'b1); exp0(16'd65534, 1'b0);
        run_bp(sb.size());

        // Reset while the divider is running.
        @(posedge CLK); #1 en = 1'b0;
        repeat (2) @(posedge CLK);
        #1 cfg_ch = 1'b0; cfg_start = 16'd10; cfg_end = 16'd20; cfg_dir = 1'b1;
        cfg_step = 16'd7; cfg_valid = 1'b1;
        @(posedge CLK); #1 cfg_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #3 SCLR_N = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_m_data", 32'(m_data), 0);
        chk("midrst_m_ch", 32'(m_ch), 0);
        chk("midrst_m_wrap", 32'(m_wrap), 0);
        chk("midrst_cfg_ready", 32'(cfg_ready), 1);
        sb.delete();
        tb_rr = 1'b0;
        @(posedge CLK); #1 SCLR_N = 1'b1;
        exp0(16'd8191, 1'b0); exp0(16'd8191, 1'b0);
        run(sb.size());
        @(negedge CLK);
        chk("post_rst_cfg_ready", 32'(cfg_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_phase_gen_mc.md
# ring_phase_gen_mc

Parametrised, multi-channel successor to the single-channel 16-bit ring counter that feeds CORDIC angle inputs in the sine-wave generator.

- Each channel owns a run-time programmable circular range (start, end, direction) and step.
- The step is reduced modulo the range length by a sequential divider when the channel is configured.
- Channels are served round-robin onto one valid/ready output stream tagged with channel number and a wrap flag.
- The block sits between the control register interface and the CORDIC angle input.

## Interface
- WIDTH, 16, sample/phase width in bits
- NUM_CH, 2, channel count (≥1)
- CH_W, 1, channel index width, ≥ clog2(NUM_CH), ≥1
- START_DEF, 16'd8191, per-channel start value after reset
- END_DEF, 16'd57344, per-channel end value after reset
- DIR_DEF, 0, per-channel direction after reset (0 = down, 1 = up)

Ports:
- CLK  in  1  rising-edge clock
- SCLR_N  in  1  asynchronous, active-low reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  block can accept configuration
- cfg_ch  in  CH_W  channel to configure
- cfg_start  in  WIDTH  range start value
- cfg_end  in  WIDTH  range end value
- cfg_dir  in  1  0 = down, 1 = up
- cfg_step  in  WIDTH  raw step per beat of that channel
- en  in  1  allow generation of new beats
- m_valid  out  1  output beat valid
- m_ready  in  1  sink accepts beat
- m_data  out  WIDTH  phase value
- m_ch  out  CH_W  channel of this beat
- m_wrap  out  1  this beat's offset was produced by a wrap

## Operation
- **Range length:** up: L = ((end − start) mod 2^WIDTH) + 1; down: L = ((start − end) mod 2^WIDTH) + 1.
  - L is held in WIDTH+1 bits; start = end+1 (up) gives L = 2^WIDTH.
- **Per-channel state:** start, dir, L, step_mod = step mod L, offset (0 ≤ offset < L), wrap_pend.
- **Reset values per channel:**
  - start/end/dir = START_DEF/END_DEF/DIR_DEF, giving L = 16384.
  - step_mod = 0, offset = 0, wrap_pend = 0.
- **Value mapping:** value = start + offset (up) or start − offset (down), mod 2^WIDTH.
  - No values are skipped; down from 8191 passes through 65535.
- **Config FSM: IDLE → LEN → DIV → COMMIT → IDLE.**
  - cfg_ready = 1 only in IDLE; accept on cfg_valid & cfg_ready and latch all cfg_* fields.
  - LEN (1 cycle): compute L.
  - DIV (exactly WIDTH cycles): restoring division, remainder of cfg_step / L; quotient discarded.
  - COMMIT (1 cycle): write start/dir/L/step_mod of cfg_ch; offset = 0, wrap_pend = 0.
  - cfg_ch ≥ NUM_CH: full FSM sequence runs, COMMIT writes nothing.
- **Beat generation:** a beat is generated when fire = en & FSM in IDLE & (!m_valid | m_ready). On fire, for channel rr:
  - m_data = value(offset[rr]), m_ch = rr, m_wrap = wrap_pend[rr], m_valid = 1.
  - s = offset + step_mod (WIDTH+1 bits); offset = s ≥ L ? s − L : s; wrap_pend = (s ≥ L).
  - rr = (rr + 1) mod NUM_CH.
- **No fire, m_valid & m_ready:** m_valid = 0.
- **Held beat:** while m_valid & !m_ready, m_data/m_ch/m_wrap are stable and no channel state advances.
- **Config vs. pending beat:** a beat already in the output register is unaffected by a later COMMIT to its channel.
- **step_mod = 0:** channel outputs start forever, m_wrap = 0.

## Timing
- Reset (asynchronous, immediate) values:
  - m_valid 0, m_data 0, m_ch 0, m_wrap 0, cfg_ready 1.
  - FSM IDLE, rr = 0, channel state as above.
- Latency: en high and m_ready high at edge t gives m_valid high after edge t; one beat per cycle thereafter.
- Config busy: accepted at edge t0.
  - cfg_ready is low for WIDTH+2 cycles (18 cycles at WIDTH=16).
  - No beats are generated during LEN/DIV/COMMIT; a held beat may still be consumed.
- Reset mid-DIV or mid-stream: all in-flight configuration is discarded; state returns to reset values.
- en low: no new beats; the current valid beat remains until accepted.

## Test plan
- Reset, NUM_CH=2, configure ch0 step=4096 (defaults otherwise), ch1 untouched, en=1, m_ready=1:
  - ch0 beats 8191, 4095, 65535, 61439, 8191 (m_wrap=1).
  - ch1 beats are all 8191; m_ch alternates 0,1.
- Up range with step > L: ch0 start=100, end=109, dir=1, step=23 (L=10, step_mod=3):
  - Sequence 100, 103, 106, 109, 102 (wrap), 105, 108, 101 (wrap).
- Zero crossing: ch0 start=65530, end=5, dir=1, step=4 (L=12):
  - Sequence 65530, 65534, 2, 65530 (wrap).
- Backpressure: m_ready=0 for 5 cycles mid-sequence:
  - Output fields stay stable; after release, the sequence continues with no skipped or repeated values.
- Config timing: cfg accepted at cycle 0:
  - cfg_ready low for 18 cycles; no new m_valid rise in that window.
  - The reconfigured channel's next beat is its start value with m_wrap=0.
- Assert SCLR_N low during DIV:
  - Outputs immediately take reset values; after release, default channel behaviour resumes (8191 with step 0).
